axis_fifo16: RTL and testbench

AXIS_FIFO16 -- requirements
Module: axis_fifo16

---
 rtl/axis_pkg.sv | 26 ++
 rtl/axis_fifo_ram.sv | 29 ++
 rtl/axis_fifo16.sv | 139 +++++++++++++
 tb/tb_axis_fifo16.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream beat definitions for the stream FIFO and its storage.
package axis_pkg;

    localparam int AXIS_DATA_W = 16;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

    // One stored beat, most significant field first; the FIFO packs its
    // payload vector in exactly this order so the two stay interchangeable.
    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic [AXIS_KEEP_W-1:0] keep;
        logic                   last;
        logic                   id;
        logic                   dest;
        logic                   user;
    } axis_beat_t;

    localparam int AXIS_BEAT_W = $bits(axis_beat_t);

    // Width of a packed beat for an arbitrary data width: data + keep
    // (one bit per byte) + last/id/dest/user.
    function automatic int beat_bits(input int data_w);
        return data_w + (data_w / 8) + 4;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately never reset; the pointers alone decide validity.
module axis_fifo_ram #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 22,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: store the beat at the write address when enabled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read keeps the head word visible in the same cycle the
    // read pointer points at it, which is what makes the FIFO fall-through.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo16.sv
// First-word-fall-through AXI-Stream FIFO with word and packet occupancy.
// Holds pointers, status flags, counters and handshake logic; the payload
// lives in axis_fifo_ram.
module axis_fifo16
    import axis_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = AXIS_DATA_W,
    localparam int KEEP_W = DATA_W / 8,
    localparam int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              axis_clk,
    input  logic              axis_rst,

    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tid,
    input  logic              s_axis_tdest,
    input  logic              s_axis_tuser,

    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tid,
    output logic              m_axis_tdest,
    output logic              m_axis_tuser,

    output logic [PTR_W-1:0]  level,
    output logic [PTR_W-1:0]  pkt_count,
    output logic              full,
    output logic              empty
);

    localparam int AW     = PTR_W - 1;
    localparam int BEAT_W = beat_bits(DATA_W);
    localparam logic [PTR_W-1:0] ONE = PTR_W'(1);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  level_q, level_d;
    logic [PTR_W-1:0]  pkt_q, pkt_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    // Holds s_axis_tready low for the first cycle after reset releases.
    logic              accept_en_q;

    logic              push;
    logic              pop;
    logic [BEAT_W-1:0] wr_beat;
    logic [BEAT_W-1:0] rd_beat;

    assign s_axis_tready = accept_en_q & ~full_q;
    assign m_axis_tvalid = ~empty_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign level         = level_q;
    assign pkt_count     = pkt_q;

    assign push = s_axis_tvalid & s_axis_tready;
    assign pop  = m_axis_tvalid & m_axis_tready;

    assign wr_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                      s_axis_tid, s_axis_tdest, s_axis_tuser};
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
            m_axis_tid, m_axis_tdest, m_axis_tuser} = rd_beat;

    axis_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BEAT_W)
    ) u_ram (
        .clk     (axis_clk),
        .we_i    (push & ~axis_rst),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_beat),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_beat)
    );

    // Next-state pointers, occupancy counters and flags from this cycle's handshakes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        pkt_d    = pkt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase

        // The popped word's tlast is the head word on the master side.
        case ({push & s_axis_tlast, pop & m_axis_tlast})
            2'b10:   pkt_d = pkt_q + ONE;
            2'b01:   pkt_d = pkt_q - ONE;
            default: pkt_d = pkt_q;
        endcase

        // Pointers span 2*DEPTH: equal low bits with differing MSBs means
        // the writer has lapped the reader exactly once.
        full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                  (wr_ptr_d[AW] != rd_ptr_d[AW]);
        empty_d = (wr_ptr_d == rd_ptr_d);
    end

    // State registers; reset discards every held word, partial packets included.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pkt_q       <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            accept_en_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            pkt_q       <= pkt_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            accept_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_fifo16.sv
// Self-checking bench for axis_fifo16: a queue-based reference model of the
// stream FIFO is compared against every DUT output on every cycle.
module tb_axis_fifo16;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 16;
    localparam int KEEP_W = 2;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int BW     = DATA_W + KEEP_W + 4;

    logic axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    logic              axis_rst;
    logic              s_axis_tvalid, s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata;
    logic [KEEP_W-1:0] s_axis_tkeep;
    logic              s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser;
    logic              m_axis_tvalid, m_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic              m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser;
    logic [LW-1:0]     level, pkt_count;
    logic              full, empty;

    axis_fifo16 #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .axis_clk      (axis_clk),
        .axis_rst      (axis_rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser),
        .level         (level),
        .pkt_count     (pkt_count),
        .full          (full),
        .empty         (empty)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;

    // Reference model: the held words in arrival order, plus whether the
    // slave side has been enabled since the last reset release.
    logic [BW-1:0] mq[$];
    bit            rdy_en     = 1'b0;
    bit            checking   = 1'b0;
    bit            prev_stall = 1'b0;
    logic [BW-1:0] prev_beat;

    wire [BW-1:0] m_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                            m_axis_tid, m_axis_tdest, m_axis_tuser};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] mk(input logic [15:0] d, input logic [1:0] k,
                                         input bit l, input bit i, input bit t, input bit u);
        return {d, k, l, i, t, u};
    endfunction

    function automatic int model_pkts();
        int cnt = 0;
        foreach (mq[i]) if (mq[i][3]) cnt++;
        return cnt;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model,
    // advance the model across the rising edge. Called at a falling edge.
    task automatic cycle(input bit rst, input bit sv, input logic [BW-1:0] beat,
                         input bit mr, output bit acc);
        bit model_ready;
        bit pop;
        axis_rst      = rst;
        s_axis_tvalid = sv;
        {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
         s_axis_tid, s_axis_tdest, s_axis_tuser} = beat;
        m_axis_tready = mr;
        #1;
        model_ready = rdy_en && (mq.size() < DEPTH);
        if (checking) begin
            check_eq("s_tready",  32'(s_axis_tready), 32'(model_ready));
            check_eq("m_tvalid",  32'(m_axis_tvalid), 32'(mq.size() != 0));
            check_eq("full",      32'(full),          32'(mq.size() == DEPTH));
            check_eq("empty",     32'(empty),         32'(mq.size() == 0));
            check_eq("level",     32'(level),         32'(mq.size()));
            check_eq("pkt_count", 32'(pkt_count),     32'(model_pkts()));
            check_eq("pkt_le_level", 32'(pkt_count <= level), 32'd1);
            if (mq.size() != 0) check_eq("head_beat", 32'(m_beat), 32'(mq[0]));
            if (prev_stall)     check_eq("stall_hold", 32'(m_beat), 32'(prev_beat));
        end
        acc = !rst && sv && model_ready;
        pop = !rst && mr && (mq.size() != 0);
        prev_stall = checking && !rst && (mq.size() != 0) && !mr;
        prev_beat  = m_beat;
        @(posedge axis_clk);
        if (rst) begin
            mq.delete();
            rdy_en = 1'b0;
        end else begin
            if (pop) begin
                n_pop++;
                $display("pop %0d: data=%h keep=%b last=%b id=%b dest=%b user=%b",
                         n_pop, mq[0][21:6], mq[0][5:4], mq[0][3], mq[0][2], mq[0][1], mq[0][0]);
                void'(mq.pop_front());
            end
            if (acc) mq.push_back(beat);
            rdy_en = 1'b1;
        end
        checking = 1'b1;
        @(negedge axis_clk);
    endtask

    task automatic idle(input bit mr, input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, mr, a);
    endtask

    task automatic do_reset(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, a);
        // Release cycle: slave side must still refuse data here.
        cycle(1'b0, 1'b1, mk(16'hDEAD, 2'b11, 1, 0, 0, 0), 1'b0, a);
    endtask

    initial begin
        bit            acc;
        int            k;
        int            b;
        logic [BW-1:0] cur;

        // Power-up reset, then a single word falls straight through.
        do_reset(3);
        cycle(1'b0, 1'b1, mk(16'hA5A5, 2'b11, 1, 1, 0, 1), 1'b0, acc);
        idle(1'b0, 2);

        // Fill to DEPTH with the reader stalled; the 17th word is refused.
        do_reset(1);
        for (int i = 0; i <= DEPTH; i++)
            cycle(1'b0, 1'b1, mk(16'(i), 2'b11, (i % 4) == 3, 0, 1, 0), 1'b0, acc);
        check_eq("full_after_16", 32'(full), 32'd1);
        check_eq("level_after_16", 32'(level), 32'(DEPTH));

        // Streaming from full: one word in and one out per cycle across the wrap.
        k = DEPTH;
        for (int i = 0; i < 45; i++) begin
            cycle(1'b0, 1'b1, mk(16'(k), 2'b11, (k % 4) == 3, 1, 1, 1), 1'b1, acc);
            if (acc) k++;
            check_eq("stream_level_hi", 32'(level >= LW'(DEPTH - 1)), 32'd1);
        end
        idle(1'b1, DEPTH + 2);

        // Three-beat packets with random valid gaps and ready stalls.
        b   = 0;
        cur = mk(16'($urandom), 2'b11, 0, 1'($urandom), 1'($urandom), 1'($urandom));
        for (int c = 0; c < 1000; c++) begin
            bit sv = ($urandom_range(0, 3) != 0);
            bit mr = (c < 500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            cycle(1'b0, sv, cur, mr, acc);
            if (acc) begin
                b   = (b + 1) % 3;
                cur = mk(16'($urandom), (b == 2) ? 2'b01 : 2'b11, b == 2,
                         1'($urandom), 1'($urandom), 1'($urandom));
            end
        end
        idle(1'b1, DEPTH + 2);

        // Reset with five words held, partway through a packet.
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1, mk(16'h5000 + 16'(i), (i == 2) ? 2'b01 : 2'b11, i == 2, 0, 0, 1), 1'b0, acc);
        check_eq("held_before_rst", 32'(level), 32'd5);
        cycle(1'b1, 1'b1, mk(16'hBAD0, 2'b11, 1, 1, 1, 1), 1'b1, acc);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_pkt", 32'(pkt_count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        idle(1'b0, 1);
        cycle(1'b0, 1'b1, mk(16'h1234, 2'b10, 1, 0, 1, 1), 1'b0, acc);

        // Long stall with data present: outputs must hold for 10 cycles.
        cycle(1'b0, 1'b1, mk(16'h4321, 2'b11, 0, 1, 0, 0), 1'b0, acc);
        idle(1'b0, 10);
        idle(1'b1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
